// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

  // Width of one UART character.
  localparam int unsigned UART_BYTE_W = 8;

  // Default number of idle owner cycles before a held grant is revoked.
  localparam int unsigned LOCK_TIMEOUT_DEFAULT = 1024;

  // Width of the idle-cycle counter.
  localparam int unsigned IDLE_CNT_W = 16;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin one-hot picker.
// The search starts at index (last+1) mod NUM_REQ. The lowest set bit of
// the rotated request vector wins.
module rr_pick #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic [NUM_REQ-1:0]         onehot
);

  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] rot_first;
  logic               found;
  int unsigned        shamt;

  // Rotate so (last+1) sits at bit 0, take the first set bit, then rotate back.
  // Rotations use a doubled vector so each one is a single plain shift.
  always_comb begin
    shamt     = 32'(last) + 32'd1;
    rot       = NUM_REQ'({req, req} >> shamt);
    rot_first = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        rot_first[i] = 1'b1;
        found        = 1'b1;
      end
    end
    onehot = NUM_REQ'({rot_first, rot_first} >> (NUM_REQ - shamt));
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates several byte requesters onto one UART transmitter. A winner
// keeps the grant for a whole burst. The grant ends when the burst completes
// or when the owner stays idle for LOCK_TIMEOUT cycles.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned LOCK_TIMEOUT = LOCK_TIMEOUT_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ*UART_BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [UART_BYTE_W-1:0]         tx_data,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           timeout_pulse
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]       last_owner_q, last_owner_d;
  logic [IDLE_CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic                   timeout_q, timeout_d;

  logic [NUM_REQ-1:0]     pick_oh;
  logic [IDX_W-1:0]       owner_idx;
  logic                   owner_valid;
  logic                   owner_last;
  logic [UART_BYTE_W-1:0] owner_data;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req    (req_valid),
    .last   (last_owner_q),
    .onehot (pick_oh)
  );

  // Select the owner's signals using the one-hot grant.
  always_comb begin
    owner_idx   = '0;
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        owner_idx   = IDX_W'(i);
        owner_valid = req_valid[i];
        owner_last  = req_last[i];
        owner_data  = req_data[i*UART_BYTE_W +: UART_BYTE_W];
      end
    end
  end

  // State, grant, round-robin pointer, idle counter and timeout strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_owner_q <= IDX_W'(NUM_REQ - 1);
      idle_cnt_q   <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_owner_q <= last_owner_d;
      idle_cnt_q   <= idle_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, then hold until the last byte or a timeout.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_owner_d = last_owner_q;
    idle_cnt_d   = idle_cnt_q;
    timeout_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        idle_cnt_d = '0;
        if (|req_valid) begin
          state_d = LOCKED;
          grant_d = pick_oh;
        end
      end
      LOCKED: begin
        if (owner_valid) begin
          idle_cnt_d = '0;
          if (tx_ready && owner_last) begin
            state_d      = IDLE;
            grant_d      = '0;
            last_owner_d = owner_idx;
          end
        end else if (idle_cnt_q == IDLE_CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_d      = IDLE;
          grant_d      = '0;
          last_owner_d = owner_idx;
          idle_cnt_d   = '0;
          timeout_d    = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Outputs: the owner is wired straight through to the transmitter, with no buffering.
  always_comb begin
    tx_valid      = (state_q == LOCKED) && owner_valid;
    tx_data       = (state_q == LOCKED) ? owner_data : '0;
    req_ready     = (state_q == LOCKED) ? (grant_q & {NUM_REQ{tx_ready}}) : '0;
    grant         = grant_q;
    timeout_pulse = timeout_q;
  end

endmodule
